tlc_phase_monitor: RTL and testbench

- Passive checker that sits on the traffic-light controller's 2-bit phase output.
- Tracks how long each phase lasts, counted in valid samples, and checks that phases follow the legal order red -> green -> yellow -> red.
- Checks each phase duration against per-phase min/max bounds and counts completed light cycles.
- Raises single-cycle error pulses and sticky error flags for system status and for simulation checking.

---
 rtl/tlc_phase_monitor_pkg.sv | 40 ++++
 rtl/tlc_phase_monitor_if.sv | 46 ++++
 rtl/tlc_phase_monitor_dwell_ctr.sv | 37 +++
 rtl/tlc_phase_monitor.sv | 129 ++++++++++++
 tb/tb_tlc_phase_monitor.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/tlc_phase_monitor_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tlc_pkg
// Brief    : Shared light encodings, FSM state type and error-bit indices
// Revision : 1.0
// ============================================================================
package tlc_pkg;

    typedef enum logic [1:0] {
        RED     = 2'b00,
        YELLOW  = 2'b01,
        ILLEGAL = 2'b10,
        GREEN   = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int c_ERR_SEQ   = 0;
    localparam int c_ERR_SHORT = 1;
    localparam int c_ERR_LONG  = 2;
    localparam int c_ERR_ENC   = 3;

    function automatic logic [1:0] next_light(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            RED:     nxt = GREEN;
            GREEN:   nxt = YELLOW;
            YELLOW:  nxt = RED;
            default: nxt = RED;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_phase_monitor_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tlc_phase_monitor_if
// Brief    : Phase-sample and status bundle; TLC_MON_LAST_DWELL_EN adds
//            last_dwell_o
// Revision : 1.0
// ============================================================================
interface tlc_phase_monitor_if #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
);
    logic [1:0]       light_in;
    logic             light_vld;
    logic             clr_err;
    logic [1:0]       phase_o;
    logic [CNT_W-1:0] dwell_o;
    logic             err_seq;
    logic             err_short;
    logic             err_long;
    logic             err_enc;
    logic [3:0]       err_sticky;
    logic [CYC_W-1:0] cycles_o;
`ifdef TLC_MON_LAST_DWELL_EN
    logic [CNT_W-1:0] last_dwell_o;
`endif

    modport master (
        output light_in, light_vld, clr_err,
`ifdef TLC_MON_LAST_DWELL_EN
        input  last_dwell_o,
`endif
        input  phase_o, dwell_o, err_seq, err_short, err_long, err_enc,
               err_sticky, cycles_o
    );

    modport slave (
        input  light_in, light_vld, clr_err,
`ifdef TLC_MON_LAST_DWELL_EN
        output last_dwell_o,
`endif
        output phase_o, dwell_o, err_seq, err_short, err_long, err_enc,
               err_sticky, cycles_o
    );
endinterface
`default_nettype wire

// File: rtl/tlc_phase_monitor_dwell_ctr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tlc_dwell_ctr
// Brief    : Saturating dwell counter with load-to-1 and a MAX->MAX+1 strobe
// Revision : 1.0
// ============================================================================
module tlc_dwell_ctr #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_inc,
    input  wire logic [CNT_W-1:0] i_max,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_over
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat  = &r_cnt;
    // Fires only on the crossing, so a long-held phase reports once.
    assign o_over = i_inc && !i_load && (r_cnt == i_max);
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(1);
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/tlc_phase_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tlc_phase_monitor
// Brief    : Passive order/dwell checker for the traffic-light phase output.
//            Optional macro TLC_MON_LAST_DWELL_EN adds last_dwell_o.
// Revision : 1.0
// ============================================================================
module tlc_phase_monitor
    import tlc_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int CYC_W   = 16,
    parameter int RED_MIN = 4,
    parameter int RED_MAX = 8,
    parameter int GRN_MIN = 4,
    parameter int GRN_MAX = 8,
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 6
) (
    input wire logic           clk,
    input wire logic           rst,
    tlc_phase_monitor_if.slave bus
);
    state_t           r_state;
    logic [1:0]       r_phase;
    logic             r_err_seq, r_err_short, r_err_long, r_err_enc;
    logic [3:0]       r_sticky;
    logic [CYC_W-1:0] r_cycles;

    logic             w_valid, w_enc, w_same, w_load, w_inc, w_chg;
    logic             w_seq, w_short, w_long;
    logic [3:0]       w_pulse;
    logic [CNT_W-1:0] w_dwell, w_min, w_max;

    always_comb begin
        w_min = CNT_W'(RED_MIN);
        w_max = CNT_W'(RED_MAX);
        case (r_phase)
            GREEN:   begin w_min = CNT_W'(GRN_MIN); w_max = CNT_W'(GRN_MAX); end
            YELLOW:  begin w_min = CNT_W'(YEL_MIN); w_max = CNT_W'(YEL_MAX); end
            default: begin w_min = CNT_W'(RED_MIN); w_max = CNT_W'(RED_MAX); end
        endcase
    end

    assign w_enc   = bus.light_vld && (bus.light_in == ILLEGAL);
    assign w_valid = bus.light_vld && (bus.light_in != ILLEGAL);
    assign w_same  = (bus.light_in == r_phase);
    assign w_load  = w_valid && ((r_state == INIT) || !w_same);
    assign w_inc   = w_valid && (r_state != INIT) && w_same;
    assign w_chg   = w_valid && (r_state != INIT) && !w_same;
    assign w_seq   = w_chg && (bus.light_in != next_light(r_phase));
    assign w_short = w_chg && (r_state == TRACK) && (w_dwell < w_min);

    always_comb begin
        w_pulse              = '0;
        w_pulse[c_ERR_SEQ]   = w_seq;
        w_pulse[c_ERR_SHORT] = w_short;
        w_pulse[c_ERR_LONG]  = w_long;
        w_pulse[c_ERR_ENC]   = w_enc;
    end

    tlc_dwell_ctr #(.CNT_W(CNT_W)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_inc  (w_inc),
        .i_max  (w_max),
        .o_cnt  (w_dwell),
        .o_over (w_long)
    );

`ifdef TLC_MON_LAST_DWELL_EN
    logic [CNT_W-1:0] r_last;
    assign bus.last_dwell_o = r_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_phase     <= RED;
            r_err_seq   <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_enc   <= 1'b0;
            r_sticky    <= '0;
            r_cycles    <= '0;
`ifdef TLC_MON_LAST_DWELL_EN
            r_last      <= '0;
`endif
        end else begin
            r_err_seq   <= w_seq;
            r_err_short <= w_short;
            r_err_long  <= w_long;
            r_err_enc   <= w_enc;
            // A pulse in the same cycle as clr_err still sets its bit.
            r_sticky    <= (bus.clr_err ? 4'b0000 : r_sticky) | w_pulse;
            if (w_valid) begin
                case (r_state)
                    INIT: begin
                        r_phase <= bus.light_in;
                        r_state <= FIRST;
                    end
                    default: begin
                        if (!w_same) begin
                            r_phase <= bus.light_in;
                            r_state <= TRACK;
                            if ((r_phase == YELLOW) && (bus.light_in == RED))
                                r_cycles <= r_cycles + 1'b1;
`ifdef TLC_MON_LAST_DWELL_EN
                            r_last <= w_dwell;
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign bus.phase_o    = r_phase;
    assign bus.dwell_o    = w_dwell;
    assign bus.err_seq    = r_err_seq;
    assign bus.err_short  = r_err_short;
    assign bus.err_long   = r_err_long;
    assign bus.err_enc    = r_err_enc;
    assign bus.err_sticky = r_sticky;
    assign bus.cycles_o   = r_cycles;
endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tlc_phase_monitor
// Brief    : Directed plus randomized checks against a sample-level model
// Revision : 1.0
// ============================================================================
module tb_tlc_phase_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    tlc_phase_monitor_if #(.CNT_W(8), .CYC_W(16)) bus ();

    tlc_phase_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state: what phase is showing, for how long, and whether it
    // is the partial first phase after reset.
    bit       m_known, m_partial;
    int       m_phase, m_dwell, m_cycles, m_last;
    bit [3:0] m_sticky;
    bit [3:0] m_pulse;
    int       mn[4], mx[4], succ[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("phase",  32'(bus.phase_o), 32'(m_phase));
        chk("dwell",  32'(bus.dwell_o), 32'(m_dwell));
        chk("pulses", 32'({bus.err_enc, bus.err_long, bus.err_short, bus.err_seq}), 32'(m_pulse));
        chk("sticky", 32'(bus.err_sticky), 32'(m_sticky));
        chk("cycles", 32'(bus.cycles_o), 32'(m_cycles));
`ifdef TLC_MON_LAST_DWELL_EN
        chk("last_dwell", 32'(bus.last_dwell_o), 32'(m_last));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.light_vld = 1'b0; bus.clr_err = 1'b0; bus.light_in = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        m_known = 0; m_partial = 0; m_phase = 0; m_dwell = 0;
        m_cycles = 0; m_last = 0; m_sticky = 0; m_pulse = 0;
        check_all();
    endtask

    task automatic step(input logic [1:0] l, input bit v, input bit c);
        m_pulse = 4'b0000;
        if (v) begin
            if (l == 2'b10) begin
                m_pulse[3] = 1'b1;
            end else if (!m_known) begin
                m_known = 1; m_partial = 1; m_phase = int'(l); m_dwell = 1;
            end else if (int'(l) == m_phase) begin
                if (m_dwell == mx[m_phase]) m_pulse[2] = 1'b1;
                if (m_dwell < 255) m_dwell++;
            end else begin
                if (succ[m_phase] != int'(l)) m_pulse[0] = 1'b1;
                if (!m_partial && m_dwell < mn[m_phase]) m_pulse[1] = 1'b1;
                if (m_phase == 1 && l == 2'b00) m_cycles = (m_cycles + 1) % 65536;
                m_last = m_dwell; m_phase = int'(l); m_dwell = 1; m_partial = 0;
            end
        end
        m_sticky = (c ? 4'b0000 : m_sticky) | m_pulse;
        bus.light_in = l; bus.light_vld = v; bus.clr_err = c;
        @(posedge clk); #1;
        bus.light_vld = 1'b0; bus.clr_err = 1'b0;
        check_all();
    endtask

    task automatic run(input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b1, 1'b0);
    endtask

    initial begin
        logic [1:0] ph;
        int         k;
        mn[0] = 4; mx[0] = 8; succ[0] = 3;   // red
        mn[3] = 4; mx[3] = 8; succ[3] = 1;   // green
        mn[1] = 2; mx[1] = 6; succ[1] = 0;   // yellow
        mn[2] = 0; mx[2] = 0; succ[2] = 0;
        bus.light_in = 2'b00; bus.light_vld = 1'b0; bus.clr_err = 1'b0;

        // One clean light cycle
        do_reset();
        run(2'b00, 5); run(2'b11, 5); run(2'b01, 3); run(2'b00, 1);
        chk("tp1_cycles", 32'(bus.cycles_o), 32'd1);
        chk("tp1_phase",  32'(bus.phase_o), 32'd0);
        chk("tp1_dwell",  32'(bus.dwell_o), 32'd1);
        chk("tp1_sticky", 32'(bus.err_sticky), 32'd0);

        // Overlong green reports exactly once
        do_reset();
        run(2'b00, 5);
        for (int i = 0; i < 9; i++) begin
            step(2'b11, 1'b1, 1'b0);
            chk("tp2_long", 32'(bus.err_long), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("tp2_sticky", 32'(bus.err_sticky), 32'b0100);

        // Short green
        do_reset();
        run(2'b00, 5); run(2'b11, 2); run(2'b01, 1);
        chk("tp3_short", 32'(bus.err_short), 32'd1);
        chk("tp3_seq",   32'(bus.err_seq), 32'd0);

        // Short red jumping straight to yellow
        run(2'b00, 3); run(2'b01, 1);
        chk("tp4_seq",   32'(bus.err_seq), 32'd1);
        chk("tp4_short", 32'(bus.err_short), 32'd1);
        chk("tp4_phase", 32'(bus.phase_o), 32'd1);

        // Illegal encoding and an invalid sample leave the dwell alone
        do_reset();
        run(2'b00, 3);
        step(2'b10, 1'b1, 1'b0);
        chk("tp5_enc", 32'(bus.err_enc), 32'd1);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        chk("tp5_dwell", 32'(bus.dwell_o), 32'd4);

        // clr_err loses to a same-cycle pulse on that pulse's bit only
        step(2'b01, 1'b1, 1'b1);
        chk("tp6_sticky", 32'(bus.err_sticky), 32'b0001);
        run(2'b00, 1); run(2'b11, 2);
        do_reset();
        chk("tp6_rst_phase", 32'(bus.phase_o), 32'd0);
        chk("tp6_rst_dwell", 32'(bus.dwell_o), 32'd0);

        // Randomized phase streams, mostly legal with occasional faults
        ph = 2'b00;
        for (int blk = 0; blk < 400; blk++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 99) < 85) ph = 2'(succ[int'(ph)]);
            else ph = 2'($urandom_range(0, 3));
            k = int'($urandom_range(1, 11));
            for (int j = 0; j < k; j++)
                step(ph, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
